pll_reset_sequencer: RTL and testbench

Sequences bring-up of the iCE40 PLL and the system reset it feeds. Runs on the 12 MHz reference clock, which is always present. Pulses the PLL's RESETB, qualifies its LOCK output, and holds the system reset until lock is stable. On lock loss, a timeout or a software restart request it re-asserts system reset and restarts the sequence. Sits at the top level, between the board oscillator/PLL and all logic clocked from the PLL output.

---
 rtl/pll_seq_if.sv | 26 ++
 rtl/pll_reset_sequencer.sv | 126 ++++++++++++
 tb/tb_pll_reset_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pll_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : pll_seq_if
// Brief    : PLL/system-reset sequencer signal bundle (PLL side + status side)
// Revision : 1.0
// ----------------------------------------------------------------------------
interface pll_seq_if;
  logic       pll_locked;
  logic       restart;
  logic       pll_resetb;
  logic       sys_resetn;
  logic       ready;
  logic [2:0] state;
  logic [7:0] retry_count;

  modport slave (
    input  pll_locked, restart,
    output pll_resetb, sys_resetn, ready, state, retry_count
  );

  modport master (
    output pll_locked, restart,
    input  pll_resetb, sys_resetn, ready, state, retry_count
  );
endinterface
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : pll_reset_sequencer
// Brief    : Pulses PLL RESETB, qualifies LOCK and holds system reset until
//            lock is stable; restarts on lock loss, timeout or request.
// Revision : 1.0
// ----------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 64,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int SYS_HOLD_CYCLES     = 256,
  parameter int CNT_W               = 16
) (
  input  wire           clk,
  input  wire           resetn,
  pll_seq_if.slave      bus
);

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD_SYS  = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_HOLD_LAST    = CNT_W'(SYS_HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stable_q, stable_d;
  logic [7:0]       retry_count_q, retry_count_d;
  logic             pll_resetb_q, pll_resetb_d;
  logic             sys_resetn_q, sys_resetn_d;
  logic             ready_q, ready_d;
  logic             lock_meta_q, lock_sync_q;
  logic             retry_inc;

  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    // A restart request overrides every other transition, but never
    // re-triggers while the PLL is already being held in reset.
    if (bus.restart && (state_q != ST_RST_PLL)) begin
      state_d = ST_RST_PLL;
    end else begin
      case (state_q)
        ST_RST_PLL: begin
          if (cnt_q == C_PLL_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_sync_q && (stable_q == C_STABLE_LAST)) begin
            state_d = ST_HOLD_SYS;
          end else if (cnt_q == C_TIMEOUT_LAST) begin
            state_d   = ST_RST_PLL;
            retry_inc = 1'b1;
          end
        end
        ST_HOLD_SYS: begin
          if (!lock_sync_q)              state_d = ST_LOST;
          else if (cnt_q == C_HOLD_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!lock_sync_q) state_d = ST_LOST;
        end
        ST_LOST: begin
          state_d   = ST_RST_PLL;
          retry_inc = 1'b1;
        end
        default: state_d = ST_RST_PLL;
      endcase
    end

    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

    stable_d = '0;
    if ((state_q == ST_WAIT_LOCK) && (state_d == ST_WAIT_LOCK) && lock_sync_q)
      stable_d = stable_q + CNT_W'(1);

    retry_count_d = retry_count_q;
    if (retry_inc && (retry_count_q != 8'hFF))
      retry_count_d = retry_count_q + 8'd1;

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register.
    pll_resetb_d = (state_d != ST_RST_PLL);
    sys_resetn_d = (state_d == ST_RUN);
    ready_d      = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_RST_PLL;
      cnt_q         <= '0;
      stable_q      <= '0;
      retry_count_q <= 8'd0;
      pll_resetb_q  <= 1'b0;
      sys_resetn_q  <= 1'b0;
      ready_q       <= 1'b0;
      lock_meta_q   <= 1'b0;
      lock_sync_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      retry_count_q <= retry_count_d;
      pll_resetb_q  <= pll_resetb_d;
      sys_resetn_q  <= sys_resetn_d;
      ready_q       <= ready_d;
      lock_meta_q   <= bus.pll_locked;
      lock_sync_q   <= lock_meta_q;
    end
  end

  assign bus.pll_resetb  = pll_resetb_q;
  assign bus.sys_resetn  = sys_resetn_q;
  assign bus.ready       = ready_q;
  assign bus.state       = state_q;
  assign bus.retry_count = retry_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_pll_reset_sequencer
// Brief    : Directed self-checking bench for pll_reset_sequencer
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  localparam int PLL_RST = 16;
  localparam int STABLE  = 64;
  localparam int TIMEOUT = 128;  // shortened so retry saturation fits the run
  localparam int HOLD    = 256;

  localparam logic [2:0] S_RST  = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_LOST = 3'd4;

  logic clk = 1'b0;
  logic resetn;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n;

  pll_seq_if bus ();

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (PLL_RST),
    .LOCK_STABLE_CYCLES  (STABLE),
    .LOCK_TIMEOUT_CYCLES (TIMEOUT),
    .SYS_HOLD_CYCLES     (HOLD),
    .CNT_W               (16)
  ) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Counts samples spent in state s, starting at the current sample.
  task automatic count_in(input logic [2:0] s, output int cnt);
    cnt = 0;
    while ((bus.state == s) && (cnt < 50000)) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int cnt);
    cnt = 0;
    while ((bus.state != s) && (cnt < budget)) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    resetn         = 1'b0;
    bus.pll_locked = 1'b0;
    bus.restart    = 1'b0;
    tick(3);
    check("rst_state", bus.state, S_RST);
    check("rst_pll_resetb", bus.pll_resetb, 0);
    check("rst_sys_resetn", bus.sys_resetn, 0);
    check("rst_ready", bus.ready, 0);
    check("rst_retry", bus.retry_count, 0);

    // Bring-up; the PLL reports lock once its reset is released
    resetn = 1'b1;
    n = 0;
    while ((bus.pll_resetb == 1'b0) && (n < 100)) begin
      n++;
      @(negedge clk);
    end
    check("pll_resetb_low_len", n, PLL_RST);
    check("enter_wait", bus.state, S_WAIT);
    bus.pll_locked = 1'b1;
    count_in(S_WAIT, n);
    check("wait_len_sync_plus_stable", n, 2 + STABLE);
    check("enter_hold", bus.state, S_HOLD);
    check("hold_sys_resetn", bus.sys_resetn, 0);
    count_in(S_HOLD, n);
    check("hold_len", n, HOLD);
    check("run_state", bus.state, S_RUN);
    check("run_sys_resetn", bus.sys_resetn, 1);
    check("run_ready", bus.ready, 1);
    check("run_pll_resetb", bus.pll_resetb, 1);
    check("run_retry", bus.retry_count, 0);

    // Restart from RUN
    tick(5);
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    check("restart_run_state", bus.state, S_RST);
    check("restart_run_sys_resetn", bus.sys_resetn, 0);
    check("restart_run_ready", bus.ready, 0);
    check("restart_run_pll_resetb", bus.pll_resetb, 0);
    check("restart_run_retry", bus.retry_count, 0);

    // One-cycle lock glitch when the stable count is 40
    wait_state(S_WAIT, 50, n);
    check("restart_rst_len", n, PLL_RST);
    tick(38);
    bus.pll_locked = 1'b0;
    tick(1);
    bus.pll_locked = 1'b1;
    count_in(S_WAIT, n);
    check("glitch_wait_len", n, 66);
    check("glitch_enter_hold", bus.state, S_HOLD);

    // Restart in HOLD_SYS, then an ignored restart inside RST_PLL
    tick(10);
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    check("restart_hold_state", bus.state, S_RST);
    check("restart_hold_sys_resetn", bus.sys_resetn, 0);
    check("restart_hold_retry", bus.retry_count, 0);
    tick(5);
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    count_in(S_RST, n);
    check("restart_in_rst_ignored", n, PLL_RST - 6);
    wait_state(S_RUN, 400, n);
    check("reseq_run_state", bus.state, S_RUN);
    check("reseq_run_len", n, STABLE + HOLD);

    // Lock loss in RUN
    bus.pll_locked = 1'b0;
    tick(2);
    check("loss_still_run", bus.state, S_RUN);
    check("loss_still_sys_resetn", bus.sys_resetn, 1);
    tick(1);
    check("loss_lost_state", bus.state, S_LOST);
    check("loss_sys_resetn", bus.sys_resetn, 0);
    check("loss_ready", bus.ready, 0);
    tick(1);
    check("loss_back_rst", bus.state, S_RST);
    check("loss_retry", bus.retry_count, 1);
    bus.pll_locked = 1'b1;
    wait_state(S_RUN, 500, n);
    check("loss_reseq_len", n, PLL_RST + STABLE + HOLD);
    check("loss_reseq_retry", bus.retry_count, 1);

    // Second loss, then a WAIT_LOCK timeout: retry_count reaches 3
    bus.pll_locked = 1'b0;
    tick(3);
    check("loss2_lost", bus.state, S_LOST);
    tick(1);
    check("loss2_retry", bus.retry_count, 2);
    wait_state(S_WAIT, 50, n);
    count_in(S_WAIT, n);
    check("timeout_len", n, TIMEOUT);
    check("timeout_state", bus.state, S_RST);
    check("timeout_retry", bus.retry_count, 3);

    // Block reset in the middle of WAIT_LOCK
    wait_state(S_WAIT, 50, n);
    tick(10);
    resetn = 1'b0;
    tick(1);
    check("midrst_state", bus.state, S_RST);
    check("midrst_pll_resetb", bus.pll_resetb, 0);
    check("midrst_sys_resetn", bus.sys_resetn, 0);
    check("midrst_ready", bus.ready, 0);
    check("midrst_retry", bus.retry_count, 0);

    // Lock never arrives: retry_count climbs and saturates at 255
    resetn = 1'b1;
    count_in(S_RST, n);
    check("sat_first_rst_len", n, PLL_RST);
    count_in(S_WAIT, n);
    check("sat_first_wait_len", n, TIMEOUT);
    check("sat_first_retry", bus.retry_count, 1);
    n = 0;
    while ((bus.retry_count != 8'd255) && (n < 60000)) begin
      tick(1);
      n++;
    end
    check("sat_reach_255", bus.retry_count, 255);
    check("sat_cycles", n, 254 * (PLL_RST + TIMEOUT));
    tick(3 * (PLL_RST + TIMEOUT));
    check("sat_no_wrap", bus.retry_count, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
